// File: rtl/tcdm_bank_rr_arbiter_if.sv
// Request/response and bank-side bundle of one TCDM bank arbiter.
// The slave modport is the arbiter; the master modport drives its inputs.
interface tcdm_bank_rr_arbiter_if #(
  parameter int NB_MASTERS = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
);
  logic [NB_MASTERS-1:0]            req_i;
  logic [NB_MASTERS*ADDR_WIDTH-1:0] add_i;
  logic [NB_MASTERS-1:0]            wen_i;
  logic [NB_MASTERS*DATA_WIDTH-1:0] wdata_i;
  logic [NB_MASTERS*BE_WIDTH-1:0]   be_i;
  logic [NB_MASTERS-1:0]            gnt_o;
  logic [NB_MASTERS-1:0]            r_valid_o;
  logic [DATA_WIDTH-1:0]            r_rdata_o;
  logic                             bank_req_o;
  logic [ADDR_WIDTH-1:0]            bank_add_o;
  logic                             bank_wen_o;
  logic [DATA_WIDTH-1:0]            bank_wdata_o;
  logic [BE_WIDTH-1:0]              bank_be_o;
  logic [DATA_WIDTH-1:0]            bank_rdata_i;

  modport slave (
    input  req_i, add_i, wen_i, wdata_i, be_i, bank_rdata_i,
    output gnt_o, r_valid_o, r_rdata_o,
    output bank_req_o, bank_add_o, bank_wen_o, bank_wdata_o, bank_be_o
  );

  modport master (
    output req_i, add_i, wen_i, wdata_i, be_i, bank_rdata_i,
    input  gnt_o, r_valid_o, r_rdata_o,
    input  bank_req_o, bank_add_o, bank_wen_o, bank_wdata_o, bank_be_o
  );
endinterface

// File: rtl/tcdm_bank_rr_arbiter.sv
// Round-robin merge of NB_MASTERS single-beat TCDM requests onto one bank port,
// with the bank response steered back to the granted master one cycle later.
module tcdm_bank_rr_arbiter #(
  parameter int NB_MASTERS = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = $clog2(NB_MASTERS)
) (
  input logic                    clk_i,
  input logic                    rst_ni,
  tcdm_bank_rr_arbiter_if.slave  bus
);

  logic [ADDR_WIDTH-1:0] add_arr   [NB_MASTERS];
  logic [DATA_WIDTH-1:0] wdata_arr [NB_MASTERS];
  logic [BE_WIDTH-1:0]   be_arr    [NB_MASTERS];

  genvar gi;
  generate
    for (gi = 0; gi < NB_MASTERS; gi++) begin : g_unpack
      assign add_arr[gi]   = bus.add_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_arr[gi] = bus.wdata_i[gi*DATA_WIDTH +: DATA_WIDTH];
      assign be_arr[gi]    = bus.be_i[gi*BE_WIDTH +: BE_WIDTH];
    end
  endgenerate

  logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic                pending_q, pending_d;
  logic [ID_WIDTH-1:0] resp_id_q, resp_id_d;

  logic [ID_WIDTH-1:0]   winner;
  logic [ID_WIDTH-1:0]   cand;
  logic                  found;
  int unsigned           scan_idx;
  logic [NB_MASTERS-1:0] gnt;
  logic [NB_MASTERS-1:0] r_valid;
  logic [ADDR_WIDTH-1:0] bank_add;
  logic                  bank_wen;
  logic [DATA_WIDTH-1:0] bank_wdata;
  logic [BE_WIDTH-1:0]   bank_be;

  // Scan upward from the pointer, wrapping, and keep the first requester found.
  always_comb begin
    winner   = '0;
    cand     = '0;
    found    = 1'b0;
    scan_idx = 0;
    for (int i = 0; i < NB_MASTERS; i++) begin
      scan_idx = (int'(rr_ptr_q) + i) % NB_MASTERS;
      cand     = ID_WIDTH'(scan_idx);
      if (!found && bus.req_i[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    gnt        = '0;
    bank_add   = '0;
    bank_wen   = 1'b1;
    bank_wdata = '0;
    bank_be    = '0;
    rr_ptr_d   = rr_ptr_q;
    pending_d  = found;
    resp_id_d  = resp_id_q;
    if (found) begin
      gnt[winner] = 1'b1;
      bank_add    = add_arr[winner];
      bank_wen    = bus.wen_i[winner];
      bank_wdata  = wdata_arr[winner];
      bank_be     = be_arr[winner];
      rr_ptr_d    = (winner == ID_WIDTH'(NB_MASTERS - 1)) ? '0 : winner + ID_WIDTH'(1);
      resp_id_d   = winner;
    end
  end

  always_comb begin
    r_valid = '0;
    if (pending_q) r_valid[resp_id_q] = 1'b1;
  end

  // Async reset also drops any in-flight response; it is never replayed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q  <= '0;
      pending_q <= 1'b0;
      resp_id_q <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      pending_q <= pending_d;
      resp_id_q <= resp_id_d;
    end
  end

  assign bus.gnt_o        = gnt;
  assign bus.r_valid_o    = r_valid;
  assign bus.r_rdata_o    = bus.bank_rdata_i;
  assign bus.bank_req_o   = |bus.req_i;
  assign bus.bank_add_o   = bank_add;
  assign bus.bank_wen_o   = bank_wen;
  assign bus.bank_wdata_o = bank_wdata;
  assign bus.bank_be_o    = bank_be;

endmodule

// File: tb/tb_tcdm_bank_rr_arbiter.sv
// Bench for tcdm_bank_rr_arbiter: directed vector table, reset-mid-operation
// sequence and protocol-respecting random traffic against a scan-based model.
module tb_tcdm_bank_rr_arbiter;
  localparam int NM = 4;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  localparam logic [NM*AW-1:0] D_ADD = {10'h3A3, 10'h2A2, 10'h1A1, 10'h0A0};
  localparam logic [NM*DW-1:0] D_WD  = {32'h33333333, 32'h22222222, 32'h11111111, 32'h01010101};
  localparam logic [NM*BW-1:0] D_BE  = {4'hF, 4'hC, 4'h5, 4'h9};

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  tcdm_bank_rr_arbiter_if #(.NB_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  tcdm_bank_rr_arbiter #(.NB_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  int checks = 0;
  int failures = 0;

  // Reference state: pointer, pending response, its owner and whether it was a read.
  int m_ptr = 0;
  bit m_pend = 0;
  int m_rid = 0;
  bit m_rd = 0;

  typedef struct {
    bit              rst_before;
    logic [NM-1:0]   req;
    logic [NM-1:0]   wen;
    logic [NM*AW-1:0] add;
    logic [NM*DW-1:0] wdata;
    logic [NM*BW-1:0] be;
    logic [DW-1:0]   rdata;
    logic [NM-1:0]   exp_gnt;
    logic [NM-1:0]   exp_rv;
  } vec_t;

  vec_t tab[20];

  function automatic vec_t mk(bit r, logic [NM-1:0] req, logic [NM-1:0] wen,
                              logic [NM*AW-1:0] add, logic [NM*DW-1:0] wd,
                              logic [NM*BW-1:0] be, logic [DW-1:0] rd,
                              logic [NM-1:0] eg, logic [NM-1:0] erv);
    vec_t v;
    v.rst_before = r; v.req = req; v.wen = wen; v.add = add; v.wdata = wd;
    v.be = be; v.rdata = rd; v.exp_gnt = eg; v.exp_rv = erv;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_pend = 0; m_rid = 0; m_rd = 0;
  endtask

  // Compare every DUT output against the model for the inputs currently applied.
  task automatic check_cycle(input string tag, input bit use_tab, input logic [NM-1:0] tg,
                             input logic [NM-1:0] trv, output int w);
    logic [NM-1:0] eg, erv;
    logic [AW-1:0] ea;
    logic          ewen;
    logic [DW-1:0] ewd;
    logic [BW-1:0] ebe;
    w = -1;
    for (int i = 0; i < NM; i++) begin
      int c;
      c = (m_ptr + i) % NM;
      if (w < 0 && bus.req_i[c]) w = c;
    end
    eg = '0; ea = '0; ewen = 1'b1; ewd = '0; ebe = '0;
    if (w >= 0) begin
      eg[w] = 1'b1;
      ea    = bus.add_i[w*AW +: AW];
      ewen  = bus.wen_i[w];
      ewd   = bus.wdata_i[w*DW +: DW];
      ebe   = bus.be_i[w*BW +: BW];
    end
    erv = '0;
    if (m_pend) erv[m_rid] = 1'b1;
    chk({tag, "_gnt"}, bus.gnt_o, eg);
    chk({tag, "_bank_req"}, bus.bank_req_o, |bus.req_i);
    chk({tag, "_bank_add"}, bus.bank_add_o, ea);
    chk({tag, "_bank_wen"}, bus.bank_wen_o, ewen);
    chk({tag, "_bank_wdata"}, bus.bank_wdata_o, ewd);
    chk({tag, "_bank_be"}, bus.bank_be_o, ebe);
    chk({tag, "_r_valid"}, bus.r_valid_o, erv);
    if (m_pend && m_rd) chk({tag, "_r_rdata"}, bus.r_rdata_o, bus.bank_rdata_i);
    if (use_tab) begin
      chk({tag, "_tab_gnt"}, bus.gnt_o, tg);
      chk({tag, "_tab_rv"}, bus.r_valid_o, trv);
    end
    $display("%s req=%b gnt=%b r_valid=%b bank_add=%h wen=%b rdata=%h",
             tag, bus.req_i, bus.gnt_o, bus.r_valid_o, bus.bank_add_o,
             bus.bank_wen_o, bus.r_rdata_o);
  endtask

  task automatic model_update(input int w);
    if (w >= 0) begin
      m_ptr  = (w + 1) % NM;
      m_pend = 1;
      m_rid  = w;
      m_rd   = bus.wen_i[w];
    end else begin
      m_pend = 0;
    end
  endtask

  task automatic drive_idle();
    bus.req_i = '0; bus.wen_i = '1; bus.add_i = D_ADD;
    bus.wdata_i = D_WD; bus.be_i = D_BE; bus.bank_rdata_i = '0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk);
    #1;
    chk("reset_r_valid", bus.r_valid_o, '0);
    chk("reset_gnt", bus.gnt_o, '0);
    chk("reset_bank_wen", bus.bank_wen_o, 1'b1);
    @(negedge clk);
    rst_ni = 1'b1;
    model_reset();
  endtask

  initial begin
    int w;
    int wt[NM];
    int lastw;

    tab[0]  = mk(1, 4'b0100, 4'b1111, {10'h3A3, 10'h005, 10'h1A1, 10'h0A0}, D_WD, D_BE, 32'hDEADBEEF, 4'b0100, 4'b0000);
    tab[1]  = mk(0, 4'b0000, 4'b1111, D_ADD, D_WD, D_BE, 32'hDEADBEEF, 4'b0000, 4'b0100);
    tab[2]  = mk(1, 4'b1111, 4'b1111, D_ADD, D_WD, D_BE, 32'h12345678, 4'b0001, 4'b0000);
    tab[3]  = mk(0, 4'b1111, 4'b1111, D_ADD, D_WD, D_BE, 32'h0000_0011, 4'b0010, 4'b0001);
    tab[4]  = mk(0, 4'b1111, 4'b1111, D_ADD, D_WD, D_BE, 32'h0000_0022, 4'b0100, 4'b0010);
    tab[5]  = mk(0, 4'b1111, 4'b1111, D_ADD, D_WD, D_BE, 32'h0000_0033, 4'b1000, 4'b0100);
    tab[6]  = mk(0, 4'b1111, 4'b1111, D_ADD, D_WD, D_BE, 32'h0000_0044, 4'b0001, 4'b1000);
    tab[7]  = mk(0, 4'b1111, 4'b1111, D_ADD, D_WD, D_BE, 32'h0000_0055, 4'b0010, 4'b0001);
    tab[8]  = mk(0, 4'b1111, 4'b1111, D_ADD, D_WD, D_BE, 32'h0000_0066, 4'b0100, 4'b0010);
    tab[9]  = mk(0, 4'b1111, 4'b1111, D_ADD, D_WD, D_BE, 32'h0000_0077, 4'b1000, 4'b0100);
    tab[10] = mk(0, 4'b0000, 4'b1111, D_ADD, D_WD, D_BE, 32'h0000_0088, 4'b0000, 4'b1000);
    tab[11] = mk(0, 4'b0010, 4'b1111, D_ADD, D_WD, D_BE, 32'h0000_0099, 4'b0010, 4'b0000);
    tab[12] = mk(0, 4'b1010, 4'b1111, D_ADD, D_WD, D_BE, 32'hCAFE0001, 4'b1000, 4'b0010);
    tab[13] = mk(0, 4'b1010, 4'b1111, D_ADD, D_WD, D_BE, 32'hCAFE0002, 4'b0010, 4'b1000);
    tab[14] = mk(0, 4'b1010, 4'b1111, D_ADD, D_WD, D_BE, 32'hCAFE0003, 4'b1000, 4'b0010);
    tab[15] = mk(0, 4'b0001, 4'b1110, D_ADD, {D_WD[127:32], 32'h0000ABCD}, {D_BE[15:4], 4'b0011}, 32'h0, 4'b0001, 4'b1000);
    tab[16] = mk(0, 4'b0000, 4'b1111, D_ADD, D_WD, D_BE, 32'h0, 4'b0000, 4'b0001);
    tab[17] = mk(0, 4'b0000, 4'b1111, D_ADD, D_WD, D_BE, 32'h0, 4'b0000, 4'b0000);
    tab[18] = mk(0, 4'b0000, 4'b1111, D_ADD, D_WD, D_BE, 32'h0, 4'b0000, 4'b0000);
    tab[19] = mk(0, 4'b1111, 4'b1111, D_ADD, D_WD, D_BE, 32'h0, 4'b0010, 4'b0000);

    drive_idle();
    @(negedge clk);

    for (int k = 0; k < 20; k++) begin
      if (tab[k].rst_before) do_reset();
      bus.req_i = tab[k].req; bus.wen_i = tab[k].wen; bus.add_i = tab[k].add;
      bus.wdata_i = tab[k].wdata; bus.be_i = tab[k].be; bus.bank_rdata_i = tab[k].rdata;
      #1;
      check_cycle($sformatf("vec%0d", k), 1'b1, tab[k].exp_gnt, tab[k].exp_rv, w);
      @(posedge clk);
      model_update(w);
      @(negedge clk);
    end

    // Reset asserted while master 1's response is pending.
    do_reset();
    bus.req_i = 4'b0010;
    #1;
    check_cycle("midop_grant", 1'b1, 4'b0010, 4'b0000, w);
    @(posedge clk);
    model_update(w);
    #1;
    chk("midop_rv_pending", bus.r_valid_o, 4'b0010);
    bus.req_i = 4'b0000;
    #2;
    rst_ni = 1'b0;
    #1;
    chk("midop_rv_cleared", bus.r_valid_o, 4'b0000);
    model_reset();
    @(negedge clk);
    rst_ni = 1'b1;
    bus.req_i = 4'b0011;
    #1;
    check_cycle("midop_after", 1'b1, 4'b0001, 4'b0000, w);
    @(posedge clk);
    model_update(w);
    @(negedge clk);

    // Random traffic; a master keeps its request and payload until granted.
    for (int i = 0; i < NM; i++) wt[i] = 0;
    lastw = w;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < NM; i++) begin
        if (!bus.req_i[i] || lastw == i) begin
          wt[i] = 0;
          if ($urandom_range(0, 99) < 60) begin
            bus.req_i[i] = 1'b1;
            bus.add_i[i*AW +: AW] = AW'($urandom);
            bus.wen_i[i] = 1'($urandom_range(0, 1));
            bus.wdata_i[i*DW +: DW] = $urandom;
            bus.be_i[i*BW +: BW] = BW'($urandom);
          end else begin
            bus.req_i[i] = 1'b0;
          end
        end
      end
      bus.bank_rdata_i = $urandom;
      #1;
      check_cycle($sformatf("rnd%0d", cyc), 1'b0, '0, '0, w);
      for (int i = 0; i < NM; i++) begin
        if (bus.req_i[i]) wt[i]++;
        if (bus.gnt_o[i]) chk($sformatf("rnd%0d_fair_m%0d", cyc, i), (wt[i] <= NM), 1'b1);
      end
      @(posedge clk);
      model_update(w);
      lastw = w;
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tcdm_bank_rr_arbiter.md
Name: tcdm_bank_rr_arbiter

Overview:
Per-bank request arbiter placed directly upstream of one L1 TCDM bank. It merges NB_MASTERS single-beat TCDM requests onto one bank port using fair round-robin arbitration. It grants one master per cycle, tracks which master was served, and returns the bank's read data with r_valid one cycle later to that master only. NB_BANKS instances sit between the cluster interconnect and the bank array.

Parameters:
NB_MASTERS, 4, number of requesting ports; must be >= 2
ADDR_WIDTH, 10, bank word-address width; equals $clog2(BANK_SIZE)
DATA_WIDTH, 32, data width
BE_WIDTH, DATA_WIDTH/8, byte-enable width
ID_WIDTH, $clog2(NB_MASTERS), width of the internal winner index

Ports:
clk_i  in  1  cluster clock
rst_ni  in  1  asynchronous active-low reset
req_i  in  NB_MASTERS  per-master request
add_i  in  NB_MASTERS*ADDR_WIDTH  per-master word address, master m at slice [m*ADDR_WIDTH +: ADDR_WIDTH]
wen_i  in  NB_MASTERS  per-master write enable, active-low (1 = read, 0 = write)
wdata_i  in  NB_MASTERS*DATA_WIDTH  per-master write data
be_i  in  NB_MASTERS*BE_WIDTH  per-master byte enables
gnt_o  out  NB_MASTERS  per-master grant, one-hot or zero
r_valid_o  out  NB_MASTERS  per-master response valid, one-hot or zero
r_rdata_o  out  DATA_WIDTH  response data, shared by all masters
bank_req_o  out  1  bank request
bank_add_o  out  ADDR_WIDTH  bank address
bank_wen_o  out  1  bank write enable, active-low
bank_wdata_o  out  DATA_WIDTH  bank write data
bank_be_o  out  BE_WIDTH  bank byte enables
bank_rdata_i  in  DATA_WIDTH  bank read data, valid one cycle after an accepted request

Behaviour:
- Clock and reset: single clock clk_i; rst_ni is asynchronous and active-low.
- Reset values:
  - rr_ptr = 0.
  - Response-pending flag = 0.
  - Response ID = 0.
  - All r_valid_o = 0.
- Request and grant path (combinational, zero latency):
  - Winner = first asserted req_i scanning upward from rr_ptr, wrapping from NB_MASTERS-1 to 0.
  - gnt_o[winner] = 1; all other bits of gnt_o = 0.
  - If no req_i is asserted, gnt_o = 0 and bank_req_o = 0.
- Bank port drive:
  - bank_req_o = |req_i.
  - bank_add_o, bank_wen_o, bank_wdata_o, bank_be_o are multiplexed from the winner.
  - When idle, bank_wen_o = 1 and all other bank fields are 0.
- Pointer update: on every cycle with a grant, rr_ptr <= winner+1, wrapping to 0 after NB_MASTERS-1. With no grant, rr_ptr holds.
- Fairness: a continuously requesting master is granted within at most NB_MASTERS cycles.
- Response path (one-cycle latency):
  - On a grant cycle, register pending <= 1 and resp_id <= winner; otherwise pending <= 0.
  - r_valid_o[resp_id] = pending, asserted in the cycle after the grant for both reads and writes.
  - r_rdata_o = bank_rdata_i, passed combinationally in the response cycle.
  - r_rdata_o is don't-care for writes; the bench does not check it.
- Back-to-back: a grant and a response to different masters, or to the same master, may occur in the same cycle. There are no bubbles and throughput is 1 request per cycle.
- Handshake rules:
  - A master holds req_i and its payload stable until gnt_o is seen.
  - Deasserting req_i without a grant is a protocol violation; the arbiter does not detect it.
- Reset mid-operation: asserting rst_ni low while a response is pending clears r_valid_o immediately (asynchronous) and returns rr_ptr to 0. The lost response is not replayed.
- No internal buffering: gnt_o carries backpressure directly; the bank never stalls.

Test Plan:
- Single read: reset, then master 2 requests a read at add=0x05 with bank_rdata=0xDEADBEEF. Required: gnt_o=0100 and bank_add_o=0x05 in that cycle; next cycle r_valid_o=0100 and r_rdata_o=0xDEADBEEF.
- All four masters request continuously from reset for 8 cycles. Required: grant order 0,1,2,3,0,1,2,3; r_valid_o follows the same order, each one cycle late.
- Pointer wrap and skip: masters 1 and 3 request with rr_ptr=2. Required: grant 3, then 1, then 3; idle masters are never granted.
- Write pass-through: master 0 writes wen=0, be=0011, wdata=0x0000ABCD. Required: bank_wen_o=0, bank_be_o=0011 and bank_wdata_o=0x0000ABCD in the same cycle; next cycle r_valid_o=0001.
- Idle: req_i=0000 for 3 cycles after traffic. Required: bank_req_o=0 and gnt_o=0000; r_valid_o=0000 from the second idle cycle on; rr_ptr unchanged.
- Reset mid-op: grant master 1, then assert rst_ni low before the next clock edge. Required: r_valid_o=0000 immediately; after release, master 0 wins against master 1.
